// File: rtl/move_cmd_gen_pkg.sv
// move_cmd_gen_pkg: direction codes, FSM state type and a one-hot helper
// shared by the move command generator.
`default_nettype none

package move_cmd_gen_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_cmd_gen_btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a per-bit stability counter;
// the output follows the input only after DB_CYCLES consecutive disagreeing cycles.
`default_nettype none

module btn_debounce #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter stops at CNT_LAST, so it can never wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q >= CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/move_cmd_gen.sv
// move_cmd_gen: turns four debounced buttons into a one-hot direction code
// plus a move strobe, with hold-to-repeat.
`default_nettype none

module move_cmd_gen
  import move_cmd_gen_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 250000,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned REP_DELAY  = 12500000,
  parameter int unsigned REP_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic [3:0] btn_raw,
  output logic [3:0] direction,
  output logic       move_pulse,
  output logic [3:0] btn_stable
);

  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW  = $clog2(REP_MAX + 1) + 1;
  localparam int RW1 = RW + 1;
  localparam logic [RW:0] LIM_FIRST = RW1'(REP_DELAY);
  localparam logic [RW:0] LIM_NEXT  = RW1'(REP_PERIOD);
  localparam logic [7:0]  PLEN      = 8'(PULSE_LEN);

  logic [3:0] w_stable;

  for (genvar g = 0; g < 4; g++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i    (clk),
      .rst_i    (rst_btn),
      .raw_i    (btn_raw[g]),
      .stable_o (w_stable[g])
    );
  end

  state_e        state_q;
  logic [3:0]    dir_q;
  logic          pulse_q;
  logic [7:0]    pcnt_q;
  logic [RW-1:0] rep_q;
  logic          first_q;

  // The HOLD decision is taken two cycles ahead of the rise (SETUP sits between),
  // so the timer is compared against limit-2.
  logic [RW:0] w_rep_ext;
  logic        w_rep_hit;
  assign w_rep_ext = {1'b0, rep_q} + RW1'(2);
  assign w_rep_hit = (REP_DELAY != 0) && (w_rep_ext >= (first_q ? LIM_FIRST : LIM_NEXT));

  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      pulse_q <= 1'b0;
      pcnt_q  <= '0;
      rep_q   <= '0;
      first_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pulse_q <= 1'b0;
          dir_q   <= DIR_NONE;
          rep_q   <= '0;
          if (is_onehot4(w_stable)) begin
            dir_q   <= w_stable;
            first_q <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          pulse_q <= 1'b1;
          pcnt_q  <= 8'd1;
          rep_q   <= '0;
          state_q <= ST_PULSE;
        end
        ST_PULSE: begin
          if (rep_q != '1) rep_q <= rep_q + 1'b1;
          if (pcnt_q >= PLEN) begin
            pulse_q <= 1'b0;
            state_q <= ST_HOLD;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (rep_q != '1) rep_q <= rep_q + 1'b1;
          // Release wins over a repeat expiring in the same cycle.
          if (w_stable != dir_q) begin
            dir_q   <= DIR_NONE;
            state_q <= ST_IDLE;
          end else if (w_rep_hit) begin
            first_q <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign direction  = dir_q;
  assign move_pulse = pulse_q;
  assign btn_stable = w_stable;

endmodule

`default_nettype wire

// File: tb/tb_move_cmd_gen.sv
// tb_move_cmd_gen: directed scenarios plus random button traffic, checked every
// cycle against a timeline-based reference model.
`default_nettype none

module tb_move_cmd_gen;

  localparam int DB = 8;
  localparam int PL = 4;
  localparam int RD = 40;
  localparam int RP = 20;

  logic       clk = 1'b0;
  logic       rst_btn = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] direction;
  logic       move_pulse;
  logic [3:0] btn_stable;

  always #5 clk = ~clk;

  move_cmd_gen #(
    .DB_CYCLES  (DB),
    .PULSE_LEN  (PL),
    .REP_DELAY  (RD),
    .REP_PERIOD (RP)
  ) dut (
    .clk        (clk),
    .rst_btn    (rst_btn),
    .btn_raw    (btn_raw),
    .direction  (direction),
    .move_pulse (move_pulse),
    .btn_stable (btn_stable)
  );

  int vectors = 0;
  int errs    = 0;

  // Model: raw history per cycle since reset, debounced level, and a press
  // timeline anchored at its first pulse rise r0.
  logic [3:0] raw_hist [0:16383];
  int         c;
  logic [3:0] m_stable;
  logic [3:0] m_dir;
  bit         m_active;
  int         r0;

  // Phase of cycle e relative to the first rise: 0 setup, 1 pulse, 2 hold.
  function automatic int phase(input int e);
    int lr;
    int nr;
    if (e < 0) return 0;
    if (RD == 0 || e < RD) lr = 0;
    else                   lr = RD + ((e - RD) / RP) * RP;
    if (RD == 0)     nr = -10;
    else if (e < RD) nr = RD;
    else             nr = lr + RP;
    if (e - lr < PL) return 1;
    if (e + 1 == nr) return 0;
    return 2;
  endfunction

  function automatic logic [3:0] sync_at(input int k);
    if (k - 2 >= 0) return raw_hist[k-2];
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, c);
    end
  endtask

  task automatic check_now();
    logic [3:0] e_dir;
    logic       e_pulse;
    e_dir   = 4'b0000;
    e_pulse = 1'b0;
    if (m_active) begin
      e_dir   = m_dir;
      e_pulse = (phase(c - r0) == 1);
    end
    chk("direction",  direction,            e_dir);
    chk("move_pulse", {3'b000, move_pulse}, {3'b000, e_pulse});
    chk("btn_stable", btn_stable,           m_stable);
  endtask

  task automatic advance(input logic [3:0] raw);
    logic [3:0] new_st;
    logic [3:0] s;
    bit         flip;
    raw_hist[c] = raw;
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int k = c - DB + 1; k <= c; k++) begin
        s = sync_at(k);
        if (s[b] == m_stable[b]) flip = 1'b0;
      end
      new_st[b] = flip ? ~m_stable[b] : m_stable[b];
    end
    if (!m_active) begin
      if ($countones(m_stable) == 1) begin
        m_active = 1'b1;
        m_dir    = m_stable;
        r0       = c + 2;
      end
    end else if (phase(c - r0) == 2 && m_stable != m_dir) begin
      m_active = 1'b0;
    end
    m_stable = new_st;
    c++;
  endtask

  task automatic cyc(input logic [3:0] raw);
    check_now();
    btn_raw = raw;
    advance(raw);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    repeat (n) cyc(raw);
  endtask

  task automatic model_reset();
    c        = 0;
    m_stable = 4'b0000;
    m_dir    = 4'b0000;
    m_active = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic apply_reset();
    rst_btn = 1'b1;
    #1;
    chk("rst_direction",  direction,            4'b0000);
    chk("rst_move_pulse", {3'b000, move_pulse}, 4'b0000);
    chk("rst_btn_stable", btn_stable,           4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_btn = 1'b0;
    model_reset();
  endtask

  initial begin
    bit         found;
    logic [3:0] pat;
    int         len;
    int         per;

    model_reset();
    rst_btn = 1'b1;
    btn_raw = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_btn = 1'b0;
    model_reset();

    // Single held button with first repeat, then release.
    hold(4'b0000, 3);
    hold(4'b1000, 60);
    hold(4'b0000, 30);

    // Chatter shorter than the debounce window.
    for (int i = 0; i < 5; i++) begin
      hold(4'b0010, 5);
      hold(4'b0000, 5);
    end
    hold(4'b0000, 10);

    // Two buttons together are not a press.
    hold(4'b1001, 30);
    hold(4'b0000, 15);

    // Long hold: first repeat at +40 then every 20.
    hold(4'b0001, 100);
    hold(4'b0000, 20);

    // Reset during the second pulse cycle, then a normal re-press.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_active && (c - r0) == 1) found = 1'b1;
      else cyc(4'b1000);
    end
    vectors++;
    assert (found)
    else begin
      errs++;
      $error("FAIL reach_pulse: observed %0d expected %0d", found, 1);
    end
    if (found) apply_reset();
    hold(4'b1000, 2);
    hold(4'b0000, 10);
    hold(4'b1000, 30);
    hold(4'b0000, 20);

    // Direction change while held passes through IDLE.
    hold(4'b1000, 40);
    hold(4'b0100, 40);
    hold(4'b0000, 20);

    // Random traffic.
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0: begin
          pat = 4'b0001;
          pat = pat << $urandom_range(0, 3);
          hold(pat, $urandom_range(10, 90));
        end
        1: hold(4'b0000, $urandom_range(5, 30));
        2: hold(4'($urandom_range(0, 15)), $urandom_range(5, 60));
        default: begin
          pat = 4'b0001;
          pat = pat << $urandom_range(0, 3);
          per = $urandom_range(1, 9);
          len = $urandom_range(10, 60);
          for (int i = 0; i < len; i++) cyc(((i / per) % 2 == 0) ? pat : 4'b0000);
        end
      endcase
      if ($urandom_range(0, 9) == 0) apply_reset();
    end
    hold(4'b0000, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/move_cmd_gen.md
MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, 250000, consecutive stable clk cycles for a raw button change to be accepted.
REQ-002 Parameter PULSE_LEN, 4, clk cycles move_pulse stays high per move; legal range 1..255.
REQ-003 Parameter REP_DELAY, 12500000, cycles from first pulse rise to first auto-repeat; 0 disables auto-repeat.
REQ-004 Parameter REP_PERIOD, 5000000, cycles between subsequent auto-repeat pulse rises; must be > PULSE_LEN+1.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 rst_btn  input  1  asynchronous active-high reset.
REQ-008 btn_raw  input  4  raw active-high buttons, bit3 up, bit2 down, bit1 left, bit0 right; asynchronous to clk.
REQ-009 direction  output  4  registered one-hot move code (1000 up, 0100 down, 0010 left, 0001 right); 0000 when no move is held.
REQ-010 move_pulse  output  1  registered move strobe; rising edge is the move event for the downstream game logic.
REQ-011 btn_stable  output  4  registered debounced button levels.

Function
REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchronizer (reset 0) before debouncing.
REQ-013 Per bit, btn_stable SHALL change only after the synchronized value differs from btn_stable for DB_CYCLES consecutive cycles; any reversal restarts that bit's counter at 0.
REQ-014 A valid press is btn_stable exactly one-hot; zero or multiple set bits are "no press".
REQ-015 FSM states: IDLE, SETUP, PULSE, HOLD.
REQ-016 IDLE: direction=0000, move_pulse=0; on valid press latch btn_stable into direction, go SETUP.
REQ-017 SETUP: exactly 1 cycle, direction valid, move_pulse=0 (setup before the strobe edge); go PULSE.
REQ-018 PULSE: move_pulse=1 for exactly PULSE_LEN cycles, direction unchanged; then go HOLD.
REQ-019 HOLD: move_pulse=0, direction held; if btn_stable != direction go IDLE (direction clears next cycle).
REQ-020 Repeat timer SHALL start at 0 on the cycle move_pulse first rises for a press; when REP_DELAY!=0 and timer reaches REP_DELAY (first repeat) or REP_PERIOD since last rise (later repeats) while in HOLD with press unchanged, go SETUP.
REQ-021 Release check in HOLD has priority over a repeat expiring in the same cycle.
REQ-022 Button changes during SETUP/PULSE SHALL NOT shorten the pulse or alter direction; they are evaluated on HOLD entry.
REQ-023 Direction change while held (e.g. up to left) SHALL pass through IDLE, giving ≥1 cycle of direction=0000 before the new SETUP.
REQ-024 Counters SHALL saturate, never wrap; widths sized by $clog2 of their parameter +1.
REQ-025 Consecutive move_pulse rises for one held button are exactly REP_PERIOD cycles apart after the first repeat.

Reset
REQ-026 rst_btn high SHALL immediately force state IDLE, direction=0000, move_pulse=0, btn_stable=0000, synchronizers and all counters 0, including mid-PULSE.
REQ-027 After rst_btn falls, a button already held SHALL produce a move only after full synchronizer + DB_CYCLES latency.

Structure
REQ-028 Shared package SHALL hold DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT 4-bit constants and the FSM state enum.
REQ-029 One sub-module btn_debounce (1-bit synchronizer + debounce counter, parameter DB_CYCLES) SHALL be instantiated 4 times.

Verification (DB_CYCLES=8, PULSE_LEN=4, REP_DELAY=40, REP_PERIOD=20)
REQ-030 Hold btn_raw=1000 for 60 cycles -> direction=1000 one cycle before move_pulse, move_pulse high exactly 4 cycles, rises at t0 and t0+40, direction=0000 after release debounced.
REQ-031 btn_raw=0010 toggling every 5 cycles for 50 cycles -> btn_stable stays 0000, no move_pulse.
REQ-032 btn_raw=1001 held 30 cycles -> no move_pulse, direction=0000 throughout.
REQ-033 Hold 0001 for 100 cycles -> pulse rises at t0, t0+40, t0+60, t0+80; each 4 cycles wide.
REQ-034 Assert rst_btn during 2nd cycle of PULSE -> move_pulse and direction 0 same cycle; re-press after release -> normal single pulse.
REQ-035 Held 1000 switched to 0100 in HOLD -> ≥1 cycle direction=0000, then 0100 with one SETUP cycle before pulse.
